// File: rtl/uart_stim_pkg.sv
// rtl/uart_stim_pkg.sv - shared types and constants for the uart_stim transmitter
// Holds the sequencer state encoding, the parity-mode constants and the
// parity helper used when a character is loaded for transmission.
package uart_stim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Unused upper data bits are zero, so they never disturb the XOR.
   function automatic logic parity_bit(input int mode, input logic [7:0] data);
      return (mode == PAR_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// rtl/uart_stim_fifo.sv - character queue feeding the uart_stim sequencer
// Ports:
//   clk_i / rst_i     clock, synchronous active-high reset
//   push_i, wdata_i   write request and character
//   pop_i, rdata_o    read request and head character (valid while !empty_o)
//   full_o, empty_o   occupancy status
//   ovf_o             sticky, set when a push is dropped
module uart_stim_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             ovf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             ovf_q;
   logic             do_push, do_pop, drop;

   assign full_o  = (count_q == DEPTH_CNT);
   assign empty_o = (count_q == '0);
   assign ovf_o   = ovf_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a push onto a full queue
   // alongside a pop is accepted rather than dropped.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign drop    = push_i && full_o && !do_pop;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
         if (drop) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_stim.sv
// rtl/uart_stim.sv - queued asynchronous serial transmitter with cts flow control
// Ports:
//   wb_clk_i, wb_rst_i  clock, synchronous active-high reset
//   wr_stb, wr_dat      push a character (bits above DATA_BITS-1 ignored)
//   cts_n               active-low clear-to-send, sampled only at frame start
//   txd                 serial line, idle high
//   busy                frame in progress
//   full, empty, ovf    queue status, ovf sticky on a dropped push
//   done                one-cycle pulse on the last cycle of the final stop bit
module uart_stim
   import uart_stim_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int DIV        = 868,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       wr_stb,
   input  logic [7:0] wr_dat,
   input  logic       cts_n,
   output logic       txd,
   output logic       busy,
   output logic       full,
   output logic       empty,
   output logic       ovf,
   output logic       done
);

   localparam int BAUD_W = $clog2(DIV);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIV - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_BITS - 1);
   localparam logic              LAST_STOP   = 1'(STOP_BITS - 1);

   state_e                state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  stop_q, stop_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  txd_q, txd_d;
   logic                  done_q, done_d;
   logic                  pop, load, bit_end, can_start;
   logic [DATA_BITS-1:0]  fifo_rdata;

   uart_stim_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (wr_stb),
      .wdata_i (wr_dat[DATA_BITS-1:0]),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (full),
      .empty_o (empty),
      .ovf_o   (ovf)
   );

   assign can_start = !empty && !cts_n;
   assign bit_end   = (baud_q == '0);
   assign busy      = (state_q != ST_IDLE);
   assign txd       = txd_q;
   assign done      = done_q;
   assign pop       = load;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;
      load    = 1'b0;

      if (state_q != ST_IDLE) baud_d = bit_end ? BAUD_RELOAD : baud_q - 1'b1;

      unique case (state_q)
         ST_IDLE:  load = can_start;
         ST_START: if (bit_end) begin
            state_d = ST_DATA;
            bit_d   = '0;
         end
         ST_DATA:  if (bit_end) begin
            shift_d = shift_q >> 1;
            if (bit_q == LAST_BIT) begin
               state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
               stop_d  = 1'b0;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         ST_PAR:   if (bit_end) begin
            state_d = ST_STOP;
            stop_d  = 1'b0;
         end
         ST_STOP:  if (bit_end) begin
            if (stop_q == LAST_STOP) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
               load    = can_start;
            end else begin
               stop_d = stop_q + 1'b1;
            end
         end
         default:  state_d = ST_IDLE;
      endcase

      // Shared by the idle start and the gapless start straight out of STOP.
      if (load) begin
         state_d = ST_START;
         baud_d  = BAUD_RELOAD;
         shift_d = fifo_rdata;
         par_d   = parity_bit(PARITY, 8'(fifo_rdata));
      end

      // The line follows the state one cycle later; done is registered the
      // same way so it lines up with the last stop cycle seen on txd.
      unique case (state_q)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_q[0];
         ST_PAR:   txd_d = par_q;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_stim.sv
// tb/tb_uart_stim.sv - self-checking bench for uart_stim
module tb_uart_stim;

   localparam int DIV_T = 4;

   typedef struct {
      logic [7:0] data;
      logic       par;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop_ok;
      logic       stable;
      logic       done_ok;
      int         start;
   } rx_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_stb_a = 1'b0;
   logic       wr_stb_b = 1'b0;
   logic [7:0] wr_dat = 8'h00;
   logic       cts_n = 1'b0;
   logic       txd_a, busy_a, full_a, empty_a, ovf_a, done_a;
   logic       txd_b, busy_b, full_b, empty_b, ovf_b, done_b;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   exp_t exp_q[$];
   rx_t  rx_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_stim #(
      .DATA_BITS (8), .PARITY (2), .STOP_BITS (1), .DIV (DIV_T), .FIFO_DEPTH (4)
   ) dut_a (
      .wb_clk_i (clk), .wb_rst_i (rst), .wr_stb (wr_stb_a), .wr_dat (wr_dat),
      .cts_n (cts_n), .txd (txd_a), .busy (busy_a), .full (full_a),
      .empty (empty_a), .ovf (ovf_a), .done (done_a)
   );

   uart_stim #(
      .DATA_BITS (7), .PARITY (1), .STOP_BITS (2), .DIV (DIV_T), .FIFO_DEPTH (16)
   ) dut_b (
      .wb_clk_i (clk), .wb_rst_i (rst), .wr_stb (wr_stb_b), .wr_dat (wr_dat),
      .cts_n (cts_n), .txd (txd_b), .busy (busy_b), .full (full_b),
      .empty (empty_b), .ovf (ovf_b), .done (done_b)
   );

   // Line monitor: decodes one frame of the selected instance per start bit.
   int          m_sel = 0, m_db = 8, m_pen = 1, m_sb = 1;
   logic        m_act = 1'b0;
   int          m_cnt, m_len, m_idx, m_start, m_dcnt;
   logic [11:0] m_bits;
   logic        m_stable, m_t, m_d;
   rx_t         m_rec;

   always @(negedge clk) begin
      m_t = (m_sel != 0) ? txd_b : txd_a;
      m_d = (m_sel != 0) ? done_b : done_a;
      if (rst) begin
         m_act = 1'b0;
      end else begin
         if (!m_act && m_t === 1'b0) begin
            m_act = 1'b1; m_cnt = 0; m_bits = '0; m_stable = 1'b1;
            m_dcnt = 0; m_start = cyc;
            m_len = (1 + m_db + m_pen + m_sb) * DIV_T;
         end
         if (m_act) begin
            m_idx = m_cnt / DIV_T;
            if (m_cnt % DIV_T == 0) m_bits[m_idx] = m_t;
            else if (m_bits[m_idx] !== m_t) m_stable = 1'b0;
            if (m_d === 1'b1) m_dcnt++;
            if (m_cnt == m_len - 1) begin
               m_rec.data = '0;
               for (int i = 0; i < m_db; i++) m_rec.data[i] = m_bits[1+i];
               m_rec.par = (m_pen != 0) ? m_bits[1+m_db] : 1'b0;
               m_rec.stop_ok = 1'b1;
               for (int i = 1 + m_db + m_pen; i < m_len / DIV_T; i++)
                  if (m_bits[i] !== 1'b1) m_rec.stop_ok = 1'b0;
               m_rec.stable  = m_stable;
               m_rec.done_ok = (m_dcnt == 1) && (m_d === 1'b1);
               m_rec.start   = m_start;
               rx_q.push_back(m_rec);
               m_act = 1'b0;
            end
            m_cnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input bit sel, input logic [7:0] d);
      @(negedge clk);
      wr_dat = d;
      if (sel) wr_stb_b = 1'b1; else wr_stb_a = 1'b1;
      @(negedge clk);
      wr_stb_a = 1'b0;
      wr_stb_b = 1'b0;
   endtask

   task automatic expect_char(input logic [7:0] d, input logic p);
      exp_t e;
      e.data = d;
      e.par  = p;
      exp_q.push_back(e);
   endtask

   task automatic wait_frame(input string tag, input int budget);
      int c = 0;
      while (rx_q.size() == 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk({tag, "_arrived"}, 32'(rx_q.size() != 0), 32'd1);
   endtask

   task automatic check_frame(input string tag, output int start);
      rx_t  r;
      exp_t e;
      start = 0;
      chk({tag, "_avail"}, 32'(rx_q.size() != 0 && exp_q.size() != 0), 32'd1);
      if (rx_q.size() == 0 || exp_q.size() == 0) return;
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      start = r.start;
      chk({tag, "_data"},   32'(r.data),    32'(e.data));
      chk({tag, "_parity"}, 32'(r.par),     32'(e.par));
      chk({tag, "_stop"},   32'(r.stop_ok), 32'd1);
      chk({tag, "_width"},  32'(r.stable),  32'd1);
      chk({tag, "_done"},   32'(r.done_ok), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int s0, s1, busy_cnt, zeros;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_txd",   32'(txd_a),   32'd1);
      chk("rst_busy",  32'(busy_a),  32'd0);
      chk("rst_done",  32'(done_a),  32'd0);
      chk("rst_ovf",   32'(ovf_a),   32'd0);
      chk("rst_empty", 32'(empty_a), 32'd1);
      chk("rst_full",  32'(full_a),  32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single frame, start latency and busy length
      expect_char(8'h54, 1'b1);
      push(1'b0, 8'h54);
      chk("lat_empty_n",  32'(empty_a), 32'd0);
      chk("lat_busy_n",   32'(busy_a),  32'd0);
      busy_cnt = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk("lat_empty_n1", 32'(empty_a), 32'd1);
            chk("lat_txd_n1",   32'(txd_a),   32'd1);
         end
         if (i == 2) chk("lat_txd_n2", 32'(txd_a), 32'd0);
         if (busy_a) busy_cnt++;
      end
      chk("busy_cycles", 32'(busy_cnt), 32'd44);
      wait_frame("f54", 50);
      check_frame("f54", s0);

      // Back-to-back, then cts_n raised mid-frame
      expect_char(8'h41, 1'b0);
      expect_char(8'h42, 1'b0);
      push(1'b0, 8'h41);
      push(1'b0, 8'h42);
      wait_frame("f41", 200);
      check_frame("f41", s0);
      repeat (10) @(negedge clk);
      cts_n = 1'b1;
      expect_char(8'h43, 1'b1);
      push(1'b0, 8'h43);
      wait_frame("f42", 200);
      check_frame("f42", s1);
      chk("b2b_gap", 32'(s1 - s0), 32'd44);
      zeros = 0;
      repeat (100) begin
         @(negedge clk);
         if (txd_a !== 1'b1) zeros++;
      end
      chk("cts_hold_txd",  32'(zeros),      32'd0);
      chk("cts_hold_rx",   32'(rx_q.size()), 32'd0);
      chk("cts_hold_fifo", 32'(empty_a),    32'd0);
      cts_n = 1'b0;
      wait_frame("f43", 200);
      check_frame("f43", s0);

      // Overflow
      do_reset();
      cts_n = 1'b1;
      push(1'b0, 8'h07); expect_char(8'h07, 1'b1);
      push(1'b0, 8'h22); expect_char(8'h22, 1'b0);
      push(1'b0, 8'h38); expect_char(8'h38, 1'b1);
      chk("ovf_full3", 32'(full_a), 32'd0);
      push(1'b0, 8'h44); expect_char(8'h44, 1'b0);
      chk("ovf_full4", 32'(full_a), 32'd1);
      chk("ovf_pre",   32'(ovf_a),  32'd0);
      push(1'b0, 8'h55);
      chk("ovf_set",   32'(ovf_a),  32'd1);
      chk("ovf_full5", 32'(full_a), 32'd1);
      cts_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_frame("ovf_frame", 300);
         check_frame("ovf_frame", s0);
      end
      repeat (100) @(negedge clk);
      chk("ovf_no_fifth", 32'(rx_q.size()), 32'd0);
      chk("ovf_drained",  32'(empty_a),     32'd1);

      // Push and pop in the same cycle while full
      do_reset();
      cts_n = 1'b1;
      push(1'b0, 8'h81); expect_char(8'h81, 1'b0);
      push(1'b0, 8'h92); expect_char(8'h92, 1'b1);
      push(1'b0, 8'hA3); expect_char(8'hA3, 1'b0);
      push(1'b0, 8'hB4); expect_char(8'hB4, 1'b0);
      chk("sim_full_pre", 32'(full_a), 32'd1);
      @(negedge clk);
      cts_n = 1'b0;
      wr_dat = 8'hC5;
      wr_stb_a = 1'b1;
      expect_char(8'hC5, 1'b0);
      @(negedge clk);
      wr_stb_a = 1'b0;
      chk("sim_full", 32'(full_a), 32'd1);
      chk("sim_ovf",  32'(ovf_a),  32'd0);
      chk("sim_busy", 32'(busy_a), 32'd1);
      for (int k = 0; k < 5; k++) begin
         wait_frame("sim_frame", 300);
         check_frame("sim_frame", s0);
      end

      // Mode sweep on the 7O2 instance
      m_sel = 1; m_db = 7; m_pen = 1; m_sb = 2;
      expect_char(8'h7F, 1'b0);
      push(1'b1, 8'h7F);
      wait_frame("f7o2", 100);
      check_frame("f7o2", s0);
      m_sel = 0; m_db = 8; m_pen = 1; m_sb = 1;

      // Reset mid-frame with characters queued; pushes during reset ignored
      do_reset();
      push(1'b0, 8'h12);
      push(1'b0, 8'h34);
      push(1'b0, 8'h56);
      zeros = 0;
      while (txd_a !== 1'b0 && zeros < 20) begin
         @(negedge clk);
         zeros++;
      end
      chk("rmf_started", 32'(txd_a), 32'd0);
      repeat (13) @(negedge clk);
      rst = 1'b1;
      wr_dat = 8'h66;
      wr_stb_a = 1'b1;
      @(negedge clk);
      chk("rmf_txd",   32'(txd_a),   32'd1);
      chk("rmf_empty", 32'(empty_a), 32'd1);
      chk("rmf_busy",  32'(busy_a),  32'd0);
      rst = 1'b0;
      wr_stb_a = 1'b0;
      zeros = 0;
      repeat (200) begin
         @(negedge clk);
         if (txd_a !== 1'b1) zeros++;
      end
      chk("rmf_quiet", 32'(zeros),       32'd0);
      chk("rmf_rx",    32'(rx_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
